// File: rtl/boton_antirrebote.sv
// Push-button debouncer: 2-flop synchronizer feeding a validation FSM that
// accepts a new level only after DEBOUNCE_CYCLES+1 consecutive synchronized samples.
module boton_antirrebote #(
    parameter int DEBOUNCE_CYCLES = 5,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic boton_in,
    output logic boton_limpio,
    output logic pulso_press,
    output logic pulso_release
);

    typedef enum logic [1:0] {
        BAJO,
        VALIDA_ALTO,
        ALTO,
        VALIDA_BAJO
    } estado_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncMeta;
    logic             sync;
    estado_t          estado;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syncMeta <= 1'b0;
            sync     <= 1'b0;
        end else begin
            syncMeta <= boton_in;
            sync     <= syncMeta;
        end
    end

    // Pulses default low every cycle so each acceptance yields exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado        <= BAJO;
            cnt           <= '0;
            boton_limpio  <= 1'b0;
            pulso_press   <= 1'b0;
            pulso_release <= 1'b0;
        end else begin
            pulso_press   <= 1'b0;
            pulso_release <= 1'b0;
            case (estado)
                BAJO: begin
                    cnt <= '0;
                    if (sync) estado <= VALIDA_ALTO;
                end
                VALIDA_ALTO: begin
                    if (!sync) begin
                        estado <= BAJO;
                        cnt    <= '0;
                    end else if (cnt == CNT_MAX) begin
                        estado       <= ALTO;
                        cnt          <= '0;
                        boton_limpio <= 1'b1;
                        pulso_press  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ALTO: begin
                    cnt <= '0;
                    if (!sync) estado <= VALIDA_BAJO;
                end
                VALIDA_BAJO: begin
                    if (sync) begin
                        estado <= ALTO;
                        cnt    <= '0;
                    end else if (cnt == CNT_MAX) begin
                        estado        <= BAJO;
                        cnt           <= '0;
                        boton_limpio  <= 1'b0;
                        pulso_release <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    estado <= BAJO;
                    cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boton_antirrebote.sv
// Bench for boton_antirrebote: DEBOUNCE_CYCLES=5 and =1 instances share one raw input,
// both checked every cycle against a run-length reference model.
module tb_boton_antirrebote;

    logic clk;
    logic rst;
    logic boton;
    logic limpio5, press5, rel5;
    logic limpio1, press1, rel1;

    int nAssert = 0;
    int nFail   = 0;

    // Reference model state, index 0 -> D=5, index 1 -> D=1
    bit mClean[2];
    bit mPress[2];
    bit mRel[2];
    int mRun[2];
    bit mDelay[2][2];
    int pressCnt[2];
    int relCnt[2];

    boton_antirrebote #(.DEBOUNCE_CYCLES(5), .CNT_W(16)) dut5 (
        .clk(clk), .rst(rst), .boton_in(boton),
        .boton_limpio(limpio5), .pulso_press(press5), .pulso_release(rel5)
    );

    boton_antirrebote #(.DEBOUNCE_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .boton_in(boton),
        .boton_limpio(limpio1), .pulso_press(press1), .pulso_release(rel1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int debounceOf(input int m);
        return (m == 0) ? 5 : 1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkInt(input string tag, input int obs, input int exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            mClean[m] = 1'b0; mPress[m] = 1'b0; mRel[m] = 1'b0; mRun[m] = 0;
            mDelay[m][0] = 1'b0; mDelay[m][1] = 1'b0;
        end
    endtask

    // A level is accepted once D+1 consecutive samples (two edges late) differ from it.
    task automatic step();
        bit s;
        for (int m = 0; m < 2; m++) begin
            if (!rst) begin
                mClean[m] = 1'b0; mPress[m] = 1'b0; mRel[m] = 1'b0; mRun[m] = 0;
                mDelay[m][0] = 1'b0; mDelay[m][1] = 1'b0;
            end else begin
                s = mDelay[m][1];
                mDelay[m][1] = mDelay[m][0];
                mDelay[m][0] = boton;
                mPress[m] = 1'b0;
                mRel[m]   = 1'b0;
                mRun[m]   = (s != mClean[m]) ? mRun[m] + 1 : 0;
                if (mRun[m] == debounceOf(m) + 1) begin
                    mClean[m] = s;
                    mPress[m] = s;
                    mRel[m]   = !s;
                    mRun[m]   = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        pressCnt[0] += int'(press5); relCnt[0] += int'(rel5);
        pressCnt[1] += int'(press1); relCnt[1] += int'(rel1);
        chk("limpio5", limpio5, mClean[0]);
        chk("press5",  press5,  mPress[0]);
        chk("rel5",    rel5,    mRel[0]);
        chk("limpio1", limpio1, mClean[1]);
        chk("press1",  press1,  mPress[1]);
        chk("rel1",    rel1,    mRel[1]);
    endtask

    task automatic hold(input logic lvl, input int n);
        boton = lvl;
        repeat (n) step();
    endtask

    task automatic clearCounts();
        for (int m = 0; m < 2; m++) begin
            pressCnt[m] = 0;
            relCnt[m]   = 0;
        end
    endtask

    task automatic asyncReset();
        #3;
        rst = 1'b0;
        #1;
        modelReset();
        chk("arst_limpio5", limpio5, 1'b0);
        chk("arst_press5",  press5,  1'b0);
        chk("arst_rel5",    rel5,    1'b0);
        chk("arst_limpio1", limpio1, 1'b0);
    endtask

    initial begin
        rst   = 1'b0;
        boton = 1'b0;
        modelReset();
        clearCounts();
        repeat (3) step();
        chk("reset_limpio5", limpio5, 1'b0);
        chk("reset_press5",  press5,  1'b0);
        chk("reset_rel5",    rel5,    1'b0);
        rst = 1'b1;
        hold(1'b0, 3);

        // Single one-cycle glitch
        clearCounts();
        hold(1'b1, 1);
        hold(1'b0, 12);
        chkInt("glitch_press5", pressCnt[0], 0);
        chkInt("glitch_press1", pressCnt[1], 0);
        chk("glitch_limpio5", limpio5, 1'b0);

        // Three bounces, then stable high: acceptance on the 8th edge
        clearCounts();
        repeat (3) begin
            hold(1'b1, 1);
            hold(1'b0, 1);
        end
        boton = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 7) chk("press_lat_before", limpio5, 1'b0);
            if (k == 8) begin
                chk("press_lat_limpio", limpio5, 1'b1);
                chk("press_lat_pulse",  press5,  1'b1);
            end
        end
        chkInt("bounce_press_count", pressCnt[0], 1);

        // Release with bounces, then stable low
        clearCounts();
        repeat (3) begin
            hold(1'b0, 1);
            hold(1'b1, 1);
        end
        boton = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 7) chk("rel_lat_before", limpio5, 1'b1);
            if (k == 8) begin
                chk("rel_lat_limpio", limpio5, 1'b0);
                chk("rel_lat_pulse",  rel5,    1'b1);
            end
        end
        chkInt("bounce_rel_count", relCnt[0], 1);
        chkInt("bounce_press_none", pressCnt[0], 0);

        // Long hold
        clearCounts();
        hold(1'b1, 100);
        chkInt("hold_press_count", pressCnt[0], 1);
        chkInt("hold_rel_count",   relCnt[0],   0);
        chk("hold_limpio", limpio5, 1'b1);

        // Async reset while the clean output is high
        asyncReset();
        hold(1'b1, 2);
        rst = 1'b1;
        hold(1'b0, 12);

        // Reset two cycles into validation, button still high at release
        clearCounts();
        hold(1'b1, 5);
        asyncReset();
        hold(1'b1, 2);
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 7) chk("rstval_before", press5, 1'b0);
            if (k == 8) chk("rstval_pulse",  press5, 1'b1);
        end
        chkInt("rstval_press5_count", pressCnt[0], 1);
        hold(1'b0, 12);

        // DEBOUNCE_CYCLES=1: 20 ns press gives a pulse on edge 4
        clearCounts();
        boton = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) boton = 1'b0;
            step();
            if (k == 3) chk("d1_before", press1, 1'b0);
            if (k == 4) chk("d1_pulse",  press1, 1'b1);
        end
        chkInt("d1_press_count", pressCnt[1], 1);
        chkInt("d1_dut5_none",   pressCnt[0], 0);
        hold(1'b0, 6);

        // Random bursts
        for (int i = 0; i < 60; i++) begin
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
        end
        hold(1'b0, 12);
        chk("final_limpio5", limpio5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
